ram_sp_param: RTL and testbench

Parametrised single-port synchronous data memory for the RISC processor, replacing the fixed 256x16 core wrappers. It is an inferred RAM array with a req/ready handshake, a programmable 1- or 2-cycle pipelined read latency, and a hardware clear engine. The clear engine zeroes every location after reset or on request. It sits between the datapath load/store unit and data storage.

---
 rtl/ram_sp_param.sv | 153 +++++++++++++++
 tb/tb_ram_sp_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_param.sv
// ram_sp_param: single-port data RAM with req/ready handshake, 1- or 2-cycle read pipeline and a
// hardware clear engine. Define RAM_PARITY_EN to store even parity per word and flag read errors.
module ram_sp_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              clr_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              init_done_o
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);

`ifdef RAM_PARITY_EN
    localparam int unsigned MemW = DATA_W + 1;
`else
    localparam int unsigned MemW = DATA_W;
`endif
    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              init_done_q, init_done_d;
    logic              clr_we;
    logic              wr_acc;
    logic              rd_acc;
    logic [MemW-1:0]   wr_word;
    logic [MemW-1:0]   rd_word;
    logic [MemW-1:0]   mem_q [Depth];
    logic [MemW-1:0]   out_word_q;
    logic              out_vld_q;

    // clr wins over a same-cycle request, which is dropped rather than deferred.
    assign ready_o = (state_q == StIdle) & ~clr_i;
    assign wr_acc  = req_i & ready_o & we_i;
    assign rd_acc  = req_i & ready_o & ~we_i;

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        init_done_d = init_done_q;
        clr_we      = 1'b0;
        if (clr_i) begin
            state_d     = StClear;
            clr_ptr_d   = '0;
            init_done_d = 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_we    = 1'b1;
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                    if (&clr_ptr_q) begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end
                end
                StIdle: begin
                end
                default: begin
                    state_d = StClear;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StClear;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done_o = init_done_q;

`ifdef RAM_PARITY_EN
    assign wr_word = {^din_i, din_i};
`else
    assign wr_word = din_i;
`endif

    // Array has no reset; the clear engine is the only initialisation path.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            mem_q[addr_i] <= wr_word;
        end
    end

    assign rd_word = mem_q[addr_i];

    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_word_q <= '0;
                out_vld_q  <= 1'b0;
            end else begin
                out_vld_q <= rd_acc;
                if (rd_acc) begin
                    out_word_q <= rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic [MemW-1:0] s1_word_q;
        logic            s1_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_word_q  <= '0;
                s1_vld_q   <= 1'b0;
                out_word_q <= '0;
                out_vld_q  <= 1'b0;
            end else begin
                s1_vld_q  <= rd_acc;
                out_vld_q <= s1_vld_q;
                if (rd_acc) begin
                    s1_word_q <= rd_word;
                end
                if (s1_vld_q) begin
                    out_word_q <= s1_word_q;
                end
            end
        end
    end

    assign dout_o       = out_word_q[DATA_W-1:0];
    assign dout_valid_o = out_vld_q;

`ifdef RAM_PARITY_EN
    // Stored word including its parity bit must XOR to zero.
    assign parity_err_o = out_vld_q & (^out_word_q);
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: READ_LAT=1 and READ_LAT=2 instances share one stimulus stream.
module tb_ram_sp_param;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic          clr   = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] din   = '0;

    logic          rdy1, rdy2, dv1, dv2, id1, id2;
    logic [DW-1:0] do1, do2;
`ifdef RAM_PARITY_EN
    logic          pe1, pe2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_sp_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .din_i        (din),
        .clr_i        (clr),
        .ready_o      (rdy1),
        .dout_o       (do1),
        .dout_valid_o (dv1),
        .init_done_o  (id1)
`ifdef RAM_PARITY_EN
        ,
        .parity_err_o (pe1)
`endif
    );

    ram_sp_param #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .din_i        (din),
        .clr_i        (clr),
        .ready_o      (rdy2),
        .dout_o       (do2),
        .dout_valid_o (dv2),
        .init_done_o  (id2)
`ifdef RAM_PARITY_EN
        ,
        .parity_err_o (pe2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = 1'b1; we = 1'b1; addr = a; din = d;
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        step();
        req = 1'b0;
    endtask

    // Accept a read and follow it through both pipelines.
    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd(a);
        check_eq({tag, "/l1_v"}, 32'(dv1), 1);
        check_eq({tag, "/l1_d"}, 32'(do1), 32'(exp));
        check_eq({tag, "/l2_v_early"}, 32'(dv2), 0);
        step();
        check_eq({tag, "/l1_v_end"}, 32'(dv1), 0);
        check_eq({tag, "/l1_d_hold"}, 32'(do1), 32'(exp));
        check_eq({tag, "/l2_v"}, 32'(dv2), 1);
        check_eq({tag, "/l2_d"}, 32'(do2), 32'(exp));
        step();
        check_eq({tag, "/l2_v_end"}, 32'(dv2), 0);
    endtask

    // Starts just after the edge that began CLEAR (reset release or clr edge).
    task automatic wait_clear(input string tag);
        int busy_hi = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            step();
            if (rdy1 | rdy2 | id1 | id2) busy_hi++;
        end
        check_eq({tag, "/busy_hi"}, 32'(busy_hi), 0);
        step();
        check_eq({tag, "/rdy1"}, 32'(rdy1), 1);
        check_eq({tag, "/rdy2"}, 32'(rdy2), 1);
        check_eq({tag, "/id1"}, 32'(id1), 1);
        check_eq({tag, "/id2"}, 32'(id2), 1);
    endtask

    initial begin
        step();
        step();
        check_eq("rst/rdy1", 32'(rdy1), 0);
        check_eq("rst/rdy2", 32'(rdy2), 0);
        check_eq("rst/id1", 32'(id1), 0);
        check_eq("rst/id2", 32'(id2), 0);
        check_eq("rst/dv1", 32'(dv1), 0);
        check_eq("rst/dv2", 32'(dv2), 0);
        check_eq("rst/do1", 32'(do1), 0);
        check_eq("rst/do2", 32'(do2), 0);
        rst_n = 1'b1;
        wait_clear("init");

        rd_chk("rd0", 8'h00, 16'h0000);
        rd_chk("rd128", 8'h80, 16'h0000);
        rd_chk("rd255", 8'hFF, 16'h0000);

        wr(8'h3C, 16'hBEEF);
        rd_chk("raw3c", 8'h3C, 16'hBEEF);

        // Three back-to-back reads must stream without gaps.
        wr(8'h01, 16'h1111);
        wr(8'h02, 16'h2222);
        wr(8'h03, 16'h3333);
        req = 1'b1; we = 1'b0; addr = 8'h01;
        step();
        check_eq("b2b/e1_v1", 32'(dv1), 1);
        check_eq("b2b/e1_d1", 32'(do1), 32'h1111);
        check_eq("b2b/e1_v2", 32'(dv2), 0);
        addr = 8'h02;
        step();
        check_eq("b2b/e2_v1", 32'(dv1), 1);
        check_eq("b2b/e2_d1", 32'(do1), 32'h2222);
        check_eq("b2b/e2_v2", 32'(dv2), 1);
        check_eq("b2b/e2_d2", 32'(do2), 32'h1111);
        addr = 8'h03;
        step();
        req = 1'b0;
        check_eq("b2b/e3_v1", 32'(dv1), 1);
        check_eq("b2b/e3_d1", 32'(do1), 32'h3333);
        check_eq("b2b/e3_v2", 32'(dv2), 1);
        check_eq("b2b/e3_d2", 32'(do2), 32'h2222);
        step();
        check_eq("b2b/e4_v1", 32'(dv1), 0);
        check_eq("b2b/e4_v2", 32'(dv2), 1);
        check_eq("b2b/e4_d2", 32'(do2), 32'h3333);
        step();
        check_eq("b2b/e5_v2", 32'(dv2), 0);

        // clr with a simultaneous request: request dropped, array zeroed.
        wr(8'h07, 16'hA5A5);
        rd_chk("pre_clr7", 8'h07, 16'hA5A5);
        clr = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h07;
        #1;
        check_eq("clr/rdy_comb", 32'(rdy1), 0);
        step();
        clr = 1'b0; req = 1'b0;
        check_eq("clr/no_v1", 32'(dv1), 0);
        check_eq("clr/id_drop", 32'(id1), 0);
        wait_clear("clr");
        rd_chk("post_clr7", 8'h07, 16'h0000);

        // A read already in the 2-stage pipe completes across a clr edge.
        wr(8'h20, 16'h1357);
        rd(8'h20);
        clr = 1'b1;
        check_eq("infl/v1", 32'(dv1), 1);
        check_eq("infl/d1", 32'(do1), 32'h1357);
        step();
        clr = 1'b0;
        check_eq("infl/v2", 32'(dv2), 1);
        check_eq("infl/d2", 32'(do2), 32'h1357);
        check_eq("infl/rdy", 32'(rdy2), 0);
        wait_clear("infl");

        // Reset partway through CLEAR restarts the full sweep.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 100; i++) step();
        rst_n = 1'b0;
        #1;
        check_eq("rstmid/rdy", 32'(rdy1), 0);
        check_eq("rstmid/id", 32'(id1), 0);
        step();
        rst_n = 1'b1;
        wait_clear("rstmid");

        // Reset with a read in flight flushes the pipeline.
        wr(8'h44, 16'h4242);
        rd(8'h44);
        rst_n = 1'b0;
        #1;
        check_eq("rstrd/v1", 32'(dv1), 0);
        check_eq("rstrd/d1", 32'(do1), 0);
        step();
        check_eq("rstrd/v2", 32'(dv2), 0);
        check_eq("rstrd/d2", 32'(do2), 0);
        step();
        rst_n = 1'b1;
        wait_clear("rstrd");
        rd_chk("rstrd44", 8'h44, 16'h0000);

`ifdef RAM_PARITY_EN
        wr(8'h09, 16'h00FF);
        rd(8'h09);
        check_eq("par/clean_pe1", 32'(pe1), 0);
        step();
        check_eq("par/clean_pe2", 32'(pe2), 0);
        check_eq("par/clean_v2", 32'(dv2), 1);
        step();
        u_dut1.mem_q[9][0] = ~u_dut1.mem_q[9][0];
        u_dut2.mem_q[9][0] = ~u_dut2.mem_q[9][0];
        rd(8'h09);
        check_eq("par/bad_d1", 32'(do1), 32'h00FE);
        check_eq("par/bad_pe1", 32'(pe1), 1);
        step();
        check_eq("par/bad_pe1_end", 32'(pe1), 0);
        check_eq("par/bad_d2", 32'(do2), 32'h00FE);
        check_eq("par/bad_pe2", 32'(pe2), 1);
        step();
        check_eq("par/bad_pe2_end", 32'(pe2), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
